// File: rtl/cpu_pkg.sv
// Shared CPU definitions: P flag bit positions, flag instruction encodings, reset value.
// DECIMAL_MODE_EN: when undefined, the D flag is hard-wired to zero.
package cpu_pkg;

  localparam int FLAG_N = 7;
  localparam int FLAG_V = 6;
  localparam int FLAG_U = 5;
  localparam int FLAG_B = 4;
  localparam int FLAG_D = 3;
  localparam int FLAG_I = 2;
  localparam int FLAG_Z = 1;
  localparam int FLAG_C = 0;

  localparam logic [7:0] P_RESET = 8'h24;

  typedef enum logic [2:0] {
    OP_CLC = 3'd0,
    OP_SEC = 3'd1,
    OP_CLI = 3'd2,
    OP_SEI = 3'd3,
    OP_CLV = 3'd4,
    OP_CLD = 3'd5,
    OP_SED = 3'd6,
    OP_RSV = 3'd7
  } flag_op_e;

  // Force the bits that never hold state in P: U reads 1, B is only a push artefact.
  function automatic logic [7:0] p_sanitize(input logic [7:0] p);
    logic [7:0] r;
    r         = p;
    r[FLAG_U] = 1'b1;
    r[FLAG_B] = 1'b0;
`ifndef DECIMAL_MODE_EN
    r[FLAG_D] = 1'b0;
`endif
    return r;
  endfunction

endpackage

// File: rtl/irq_mask_sync.sv
// Effective IRQ mask (updated only at instruction boundaries) and registered IRQ request.
module irq_mask_sync (
  input  logic clk,
  input  logic rst,
  input  logic instr_end,
  input  logic i_next,
  input  logic irq_n,
  output logic irq_req
);

  logic i_eff;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values; irq_req therefore sees the old i_eff.
  always_ff @(posedge clk) begin
    if (rst) begin
      i_eff   <= 1'b1;
      irq_req <= 1'b0;
    end else begin
      irq_req <= ~irq_n & ~i_eff;
      if (instr_end) i_eff <= i_next;
    end
  end

endmodule

// File: rtl/proc_status.sv
// Processor status register P with flag updates, push image and interrupt masking.
// DECIMAL_MODE_EN: define to keep the D flag; otherwise D is always zero.
module proc_status
  import cpu_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] alu_flags,
  input  logic [7:0] flag_we,
  input  logic [2:0] flag_op,
  input  logic       flag_op_valid,
  input  logic       p_load,
  input  logic [7:0] p_load_data,
  input  logic       push_brk,
  input  logic       instr_end,
  input  logic       irq_n,
  output logic [7:0] p_reg,
  output logic [7:0] p_push,
  output logic       alu_carry,
  output logic       alu_daa,
  output logic       irq_req
);

  logic [7:0] p_next;

  // NOTE: p_next gets a full default before any conditional write so no latch is inferred.
  always_comb begin
    p_next = p_reg;
    if (p_load) begin
      p_next = p_load_data;
    end else begin
      p_next = (p_reg & ~flag_we) | (alu_flags & flag_we);
      // The explicit flag instruction wins over the ALU mask on its target bit.
      if (flag_op_valid) begin
        case (flag_op_e'(flag_op))
          OP_CLC:  p_next[FLAG_C] = 1'b0;
          OP_SEC:  p_next[FLAG_C] = 1'b1;
          OP_CLI:  p_next[FLAG_I] = 1'b0;
          OP_SEI:  p_next[FLAG_I] = 1'b1;
          OP_CLV:  p_next[FLAG_V] = 1'b0;
          OP_CLD:  p_next[FLAG_D] = 1'b0;
          OP_SED:  p_next[FLAG_D] = 1'b1;
          default: ;
        endcase
      end
    end
    p_next = p_sanitize(p_next);
  end

  always_ff @(posedge clk) begin
    if (rst) p_reg <= P_RESET;
    else     p_reg <= p_next;
  end

  assign p_push    = {p_reg[7:5], push_brk, p_reg[3:0]};
  assign alu_carry = p_reg[FLAG_C];
`ifdef DECIMAL_MODE_EN
  assign alu_daa   = p_reg[FLAG_D];
`else
  assign alu_daa   = 1'b0;
`endif

  // i_eff follows the next-state I, so a PLP retiring this cycle loads the pulled bit.
  irq_mask_sync u_irq_mask_sync (
    .clk       (clk),
    .rst       (rst),
    .instr_end (instr_end),
    .i_next    (p_next[FLAG_I]),
    .irq_n     (irq_n),
    .irq_req   (irq_req)
  );

endmodule

// File: tb/tb_proc_status.sv
// Scoreboard bench for proc_status: directed scenarios followed by random cycles.
module tb_proc_status;

`ifdef DECIMAL_MODE_EN
  localparam bit DEC = 1'b1;
`else
  localparam bit DEC = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] alu_flags = '0;
  logic [7:0] flag_we = '0;
  logic [2:0] flag_op = '0;
  logic       flag_op_valid = 1'b0;
  logic       p_load = 1'b0;
  logic [7:0] p_load_data = '0;
  logic       push_brk = 1'b0;
  logic       instr_end = 1'b0;
  logic       irq_n = 1'b1;
  logic [7:0] p_reg, p_push;
  logic       alu_carry, alu_daa, irq_req;

  proc_status dut (
    .clk(clk), .rst(rst), .alu_flags(alu_flags), .flag_we(flag_we),
    .flag_op(flag_op), .flag_op_valid(flag_op_valid), .p_load(p_load),
    .p_load_data(p_load_data), .push_brk(push_brk), .instr_end(instr_end),
    .irq_n(irq_n), .p_reg(p_reg), .p_push(p_push), .alu_carry(alu_carry),
    .alu_daa(alu_daa), .irq_req(irq_req)
  );

  always #5 clk = ~clk;

  typedef struct {
    string      tag;
    logic [7:0] p;
    logic [7:0] push;
    logic       irq;
  } exp_t;

  exp_t q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  // Reference state: architectural P, effective I mask, pending IRQ.
  logic [7:0] m_p    = 8'h24;
  logic       m_ieff = 1'b1;
  logic       m_irq  = 1'b0;

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, req, $time);
    end
  endtask

  // Behavioural model: flags are set or cleared by name from the instruction rules.
  task automatic model_step;
    logic [7:0] np;
    logic       new_irq;
    if (rst) begin
      m_p = 8'h24; m_ieff = 1'b1; m_irq = 1'b0;
      return;
    end
    new_irq = !irq_n && !m_ieff;
    if (p_load) np = p_load_data;
    else begin
      np = m_p;
      for (int k = 0; k < 8; k++)
        if (flag_we[k]) np[k] = alu_flags[k];
      if (flag_op_valid) begin
        case (flag_op)
          3'd0: np[0] = 1'b0;
          3'd1: np[0] = 1'b1;
          3'd2: np[2] = 1'b0;
          3'd3: np[2] = 1'b1;
          3'd4: np[6] = 1'b0;
          3'd5: np[3] = 1'b0;
          3'd6: np[3] = 1'b1;
          default: ;
        endcase
      end
    end
    np[5] = 1'b1;
    np[4] = 1'b0;
    if (!DEC) np[3] = 1'b0;
    if (instr_end) m_ieff = np[2];
    m_p   = np;
    m_irq = new_irq;
  endtask

  task automatic drive(input string tag, input logic r, input logic pl, input logic [7:0] pld,
                       input logic ov, input logic [2:0] op, input logic [7:0] we,
                       input logic [7:0] af, input logic pb, input logic ie, input logic in_n);
    exp_t e;
    @(negedge clk);
    rst = r; p_load = pl; p_load_data = pld; flag_op_valid = ov; flag_op = op;
    flag_we = we; alu_flags = af; push_brk = pb; instr_end = ie; irq_n = in_n;
    model_step();
    e.tag  = tag;
    e.p    = m_p;
    e.push = {m_p[7:5], pb, m_p[3:0]};
    e.irq  = m_irq;
    q.push_back(e);
  endtask

  // Monitor: the DUT presents a new P every cycle, sampled just after the edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() != 0) begin
        e = q.pop_front();
        check({e.tag, ".p_reg"},  p_reg,  e.p);
        check({e.tag, ".p_push"}, p_push, e.push);
        check({e.tag, ".carry"},  {7'd0, alu_carry}, {7'd0, e.p[0]});
        check({e.tag, ".daa"},    {7'd0, alu_daa},   {7'd0, e.p[3]});
        check({e.tag, ".irq"},    {7'd0, irq_req},   {7'd0, e.irq});
      end
    end
  end

  initial begin
    // tag, rst, p_load, data, op_valid, op, we, alu, push_brk, instr_end, irq_n
    drive("reset0", 1, 0, 8'h00, 0, 3'd0, 8'h00, 8'h00, 0, 0, 1);
    drive("reset1", 1, 0, 8'h00, 0, 3'd0, 8'h00, 8'h00, 1, 0, 1);
    drive("push_brk1", 0, 0, 8'h00, 0, 3'd0, 8'h00, 8'h00, 1, 0, 1);
    drive("push_brk0", 0, 0, 8'h00, 0, 3'd0, 8'h00, 8'h00, 0, 0, 1);
    drive("we83",  0, 0, 8'h00, 0, 3'd0, 8'h83, 8'h81, 0, 1, 1);
    drive("idle",  0, 0, 8'h00, 0, 3'd0, 8'h00, 8'h00, 0, 0, 1);
    drive("setz",  0, 0, 8'h00, 0, 3'd0, 8'h02, 8'h02, 0, 0, 1);
    drive("clc",   0, 0, 8'h00, 1, 3'd0, 8'h00, 8'h00, 0, 0, 1);
    drive("sec_we02", 0, 0, 8'h00, 1, 3'd1, 8'h02, 8'h00, 0, 1, 1);
    drive("sed",   0, 0, 8'h00, 1, 3'd6, 8'h00, 8'h00, 0, 0, 1);
    drive("we_d",  0, 0, 8'h00, 0, 3'd0, 8'h08, 8'h00, 0, 0, 1);
    drive("load_ff_clc", 0, 1, 8'hFF, 1, 3'd0, 8'hFF, 8'h00, 0, 0, 1);
    drive("rsv_op", 0, 0, 8'h00, 1, 3'd7, 8'h00, 8'h00, 0, 0, 1);
    // Interrupt mask lags CLI until the next instruction boundary.
    drive("irq_rst", 1, 0, 8'h00, 0, 3'd0, 8'h00, 8'h00, 0, 0, 0);
    drive("cli_noend", 0, 0, 8'h00, 1, 3'd2, 8'h00, 8'h00, 0, 0, 0);
    drive("masked0", 0, 0, 8'h00, 0, 3'd0, 8'h00, 8'h00, 0, 0, 0);
    drive("masked1", 0, 0, 8'h00, 0, 3'd0, 8'h00, 8'h00, 0, 0, 0);
    drive("iend",  0, 0, 8'h00, 0, 3'd0, 8'h00, 8'h00, 0, 1, 0);
    drive("irq_on", 0, 0, 8'h00, 0, 3'd0, 8'h00, 8'h00, 0, 0, 0);
    drive("irq_hold", 0, 0, 8'h00, 0, 3'd0, 8'h00, 8'h00, 0, 0, 0);
    drive("plp_iend", 0, 1, 8'h04, 0, 3'd0, 8'h00, 8'h00, 0, 1, 0);
    drive("plp_after", 0, 0, 8'h00, 0, 3'd0, 8'h00, 8'h00, 0, 0, 0);
    drive("rst_load", 1, 1, 8'h00, 1, 3'd1, 8'hFF, 8'hFF, 0, 1, 0);
    drive("post_rst", 0, 0, 8'h00, 0, 3'd0, 8'h00, 8'h00, 0, 0, 0);

    for (int i = 0; i < 400; i++) begin
      drive("rand",
            ($urandom_range(0, 99) < 3),
            ($urandom_range(0, 99) < 10),
            8'($urandom),
            ($urandom_range(0, 99) < 30),
            3'($urandom),
            ($urandom_range(0, 1) == 1) ? 8'($urandom) : 8'h00,
            8'($urandom),
            1'($urandom),
            ($urandom_range(0, 99) < 30),
            1'($urandom));
    end

    for (int i = 0; i < 10 && q.size() != 0; i++) @(negedge clk);
    if (q.size() != 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL drain: %0d items left expected 0", q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
